cache_dm_wb_param: RTL and testbench

- Parametrised direct-mapped, write-back, write-allocate data cache. Successor to the fixed 512-byte, 1-word-line cache.
- Sits between the 5-stage pipeline's data-memory port and a single-word latency RAM.
- Adds configurable line length with multi-word burst refill and writeback, byte-strobed writes, and hit/miss performance counters.
- Pipeline side is unchanged: stall-based, hit answered in the same cycle.

---
 rtl/cache_dm_wb_param.sv | 209 ++++++++++++++++++++
 tb/tb_cache_dm_wb_param.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_dm_wb_param.sv
// Direct-mapped, write-back, write-allocate data cache with configurable line
// length, burst refill/writeback over a single-word RAM port, and hit/miss counters.
module cache_dm_wb_param #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   cache_req_addr,
    input  logic [DATA_WIDTH-1:0]   cache_req_data,
    input  logic [DATA_WIDTH/8-1:0] cache_req_wstrb,
    input  logic                    cache_req_wen,
    input  logic                    cache_req_valid,
    output logic [DATA_WIDTH-1:0]   cache_res_data,
    output logic                    cache_res_stall,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_data,
    output logic                    mem_req_wen,
    output logic                    mem_req_valid,
    input  logic [DATA_WIDTH-1:0]   mem_res_data,
    input  logic                    mem_res_valid,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int BO = $clog2(NB);
    localparam int WI = $clog2(LINE_WORDS);
    localparam int LI = $clog2(NUM_LINES);
    localparam int TW = ADDR_WIDTH - LI - WI - BO;
    localparam int CW = (WI > 0) ? WI : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(LINE_WORDS - 1);
    localparam logic [31:0]   CNT_MAX   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   gap_q, gap_d;
    logic                   miss_pend_q;
    logic [31:0]            hit_count_q, miss_count_q;
    logic [NUM_LINES-1:0]   valid_q, dirty_q;
    logic [TW-1:0]          tag_q  [NUM_LINES];
    logic [DATA_WIDTH-1:0]  data_q [NUM_LINES][LINE_WORDS];

    logic [TW-1:0]          req_tag_s, line_tag_s;
    logic [LI-1:0]          req_idx_s;
    logic [CW-1:0]          req_word_s;
    logic                   hit_s, idle_hit_s, idle_miss_s;
    logic                   mem_active_s, xfer_s, last_s;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NB-1:0]         strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int b = 0; b < NB; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_w[8*b +: 8];
            end
        end
        return res;
    endfunction

    assign req_tag_s = cache_req_addr[ADDR_WIDTH-1 -: TW];
    assign req_idx_s = cache_req_addr[BO+WI +: LI];

    // A one-word line has no word-select field in the address.
    if (WI > 0) begin : gen_word_sel
        assign req_word_s = cache_req_addr[BO +: CW];
    end else begin : gen_word_zero
        assign req_word_s = '0;
    end

    if (BO > 0) begin : gen_byte_unused
        logic unused_byte_s;
        assign unused_byte_s = ^cache_req_addr[BO-1:0];
    end

    assign hit_s        = valid_q[req_idx_s] && (tag_q[req_idx_s] == req_tag_s);
    assign idle_hit_s   = (state_q == IDLE) && cache_req_valid && hit_s;
    assign idle_miss_s  = (state_q == IDLE) && cache_req_valid && !hit_s;
    assign mem_active_s = (state_q != IDLE) && !gap_q;
    assign xfer_s       = mem_active_s && mem_res_valid;
    assign last_s       = (cnt_q == LAST_WORD);
    assign hit_count    = hit_count_q;
    assign miss_count   = miss_count_q;

    // Next-state logic: burst sequencing over the line with a one-cycle gap per word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (idle_miss_s) begin
                    cnt_d = '0;
                    if (valid_q[req_idx_s] && dirty_q[req_idx_s]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = REFILL;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WRITEBACK, REFILL: begin
                if (xfer_s) begin
                    gap_d = 1'b1;
                    if (last_s) begin
                        cnt_d   = '0;
                        state_d = (state_q == WRITEBACK) ? REFILL : IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode; stall is masked by reset so an abort releases the pipeline at once.
    always_comb begin
        mem_req_valid   = mem_active_s;
        mem_req_wen     = mem_active_s && (state_q == WRITEBACK);
        cache_res_stall = rst && ((state_q != IDLE) || idle_miss_s);
        if (state_q == WRITEBACK) begin
            line_tag_s = tag_q[req_idx_s];
        end else begin
            line_tag_s = req_tag_s;
        end
        mem_req_addr = (ADDR_WIDTH'({line_tag_s, req_idx_s}) << (WI + BO))
                     | (ADDR_WIDTH'(cnt_q) << BO);
        mem_req_data = data_q[req_idx_s][cnt_q];
        if (idle_hit_s) begin
            cache_res_data = data_q[req_idx_s][req_word_s];
        end else begin
            cache_res_data = '0;
        end
    end

    // Control state, line status bits and saturating performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            gap_q        <= 1'b0;
            miss_pend_q  <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            if (idle_hit_s) begin
                if (cache_req_wen) begin
                    dirty_q[req_idx_s] <= 1'b1;
                end
                if (miss_pend_q) begin
                    miss_pend_q <= 1'b0;
                end else if (hit_count_q != CNT_MAX) begin
                    hit_count_q <= hit_count_q + 32'd1;
                end
            end
            if (idle_miss_s) begin
                miss_pend_q <= 1'b1;
                if (miss_count_q != CNT_MAX) begin
                    miss_count_q <= miss_count_q + 32'd1;
                end
            end
            if (xfer_s && last_s) begin
                dirty_q[req_idx_s] <= 1'b0;
                if (state_q == REFILL) begin
                    valid_q[req_idx_s] <= 1'b1;
                end
            end
        end
    end

    // Tag and data arrays; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (idle_hit_s && cache_req_wen) begin
            data_q[req_idx_s][req_word_s] <= merge_bytes(data_q[req_idx_s][req_word_s],
                                                         cache_req_data, cache_req_wstrb);
        end
        if (xfer_s && (state_q == REFILL)) begin
            data_q[req_idx_s][cnt_q] <= mem_res_data;
            if (last_s) begin
                tag_q[req_idx_s] <= req_tag_s;
            end
        end
    end
endmodule

// File: tb/tb_cache_dm_wb_param.sv
// Self-checking bench for cache_dm_wb_param: word=address RAM model with 3-cycle
// latency, a queue of expected memory transfers, and a table of hit accesses.
module tb_cache_dm_wb_param;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cache_req_addr = 32'd0;
    logic [31:0] cache_req_data = 32'd0;
    logic [3:0]  cache_req_wstrb = 4'd0;
    logic        cache_req_wen = 1'b0;
    logic        cache_req_valid = 1'b0;
    logic [31:0] cache_res_data;
    logic        cache_res_stall;
    logic [31:0] mem_req_addr, mem_req_data;
    logic        mem_req_wen, mem_req_valid;
    logic [31:0] mem_res_data = 32'd0;
    logic        mem_res_valid = 1'b0;
    logic [31:0] hit_count, miss_count;

    int checks = 0;
    int errors = 0;
    int lat = 0;
    int xfer_cnt = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;
    xfer_t exp_q[$];
    logic [31:0] ram [logic [31:0]];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        wen;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vecs[7];

    cache_dm_wb_param #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_WORDS(4), .NUM_LINES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .cache_req_addr(cache_req_addr), .cache_req_data(cache_req_data),
        .cache_req_wstrb(cache_req_wstrb), .cache_req_wen(cache_req_wen),
        .cache_req_valid(cache_req_valid),
        .cache_res_data(cache_res_data), .cache_res_stall(cache_res_stall),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_req_wen(mem_req_wen), .mem_req_valid(mem_req_valid),
        .mem_res_data(mem_res_data), .mem_res_valid(mem_res_valid),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a;
    endfunction

    // RAM model: answers a held request after 3 cycles and checks it against the scoreboard.
    always @(negedge clk) begin
        if (mem_res_valid) begin
            mem_res_valid = 1'b0;
            lat = 0;
            chk("valid_gap", {31'd0, mem_req_valid}, 32'd0);
        end else if (mem_req_valid) begin
            lat++;
            if (lat == 3) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer: got addr %h wen %b expected none", mem_req_addr, mem_req_wen);
                end else begin
                    xfer_t e;
                    e = exp_q.pop_front();
                    chk("xfer_addr", mem_req_addr, e.addr);
                    chk("xfer_wen", {31'd0, mem_req_wen}, {31'd0, e.wen});
                    if (e.wen) chk("xfer_wdata", mem_req_data, e.data);
                end
                if (mem_req_wen) ram[mem_req_addr] = mem_req_data;
                else mem_res_data = ram_rd(mem_req_addr);
                mem_res_valid = 1'b1;
            end
        end else begin
            lat = 0;
        end
    end

    task automatic push_line(input logic w, input logic [31:0] base,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3);
        exp_q.push_back('{w, base,          d0});
        exp_q.push_back('{w, base + 32'd4,  d1});
        exp_q.push_back('{w, base + 32'd8,  d2});
        exp_q.push_back('{w, base + 32'd12, d3});
    endtask

    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic w, output logic [31:0] rd, output int stalls,
                          output logic mreq);
        @(negedge clk);
        cache_req_addr = a; cache_req_data = d; cache_req_wstrb = s;
        cache_req_wen = w; cache_req_valid = 1'b1;
        #1;
        stalls = 0;
        while (cache_res_stall && stalls < 200) begin
            @(negedge clk); #1;
            stalls++;
        end
        chk("stall_bound", 32'(stalls < 200), 32'd1);
        rd = cache_res_data;
        mreq = mem_req_valid;
        @(posedge clk); #1;
        cache_req_valid = 1'b0;
    endtask

    task automatic miss(input string nm, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic w, input logic [31:0] exp_rd);
        logic [31:0] rd;
        int st;
        logic mq;
        access(a, d, s, w, rd, st, mq);
        exp_misses++;
        chk({nm, "_stalled"}, 32'(st > 0), 32'd1);
        if (!w) chk({nm, "_rdata"}, rd, exp_rd);
        chk({nm, "_miss_cnt"}, miss_count, 32'(exp_misses));
        chk({nm, "_hit_cnt"}, hit_count, 32'(exp_hits));
        chk({nm, "_xfers_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int st;
        logic mq;
        int base;

        vecs[0] = '{32'h104, 32'h0,        4'h0,    1'b0, 32'h0000_0104};
        vecs[1] = '{32'h10C, 32'h0,        4'h0,    1'b0, 32'h0000_010C};
        vecs[2] = '{32'h108, 32'hAABBCCDD, 4'b0011, 1'b1, 32'h0};
        vecs[3] = '{32'h108, 32'h0,        4'h0,    1'b0, 32'h0000_CCDD};
        vecs[4] = '{32'h104, 32'h11223344, 4'b1000, 1'b1, 32'h0};
        vecs[5] = '{32'h104, 32'h0,        4'h0,    1'b0, 32'h1100_0104};
        vecs[6] = '{32'h100, 32'h0,        4'h0,    1'b0, 32'h0000_0100};

        #1;
        chk("rst_stall", {31'd0, cache_res_stall}, 32'd0);
        chk("rst_mvalid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_mwen", {31'd0, mem_req_wen}, 32'd0);
        chk("rst_rdata", cache_res_data, 32'd0);
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_misses", miss_count, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        push_line(1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0);
        miss("cold_read", 32'h100, 32'h0, 4'h0, 1'b0, 32'h100);

        for (int i = 0; i < 7; i++) begin
            access(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].wen, rd, st, mq);
            exp_hits++;
            chk($sformatf("hit%0d_stall", i), 32'(st), 32'd0);
            chk($sformatf("hit%0d_no_mem", i), {31'd0, mq}, 32'd0);
            if (!vecs[i].wen) chk($sformatf("hit%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("hit%0d_hit_cnt", i), hit_count, 32'(exp_hits));
        end

        push_line(1'b1, 32'h100, 32'h100, 32'h1100_0104, 32'h0000_CCDD, 32'h10C);
        push_line(1'b0, 32'h180, 32'h0, 32'h0, 32'h0, 32'h0);
        miss("dirty_evict", 32'h180, 32'h0, 4'h0, 1'b0, 32'h180);

        push_line(1'b0, 32'h200, 32'h0, 32'h0, 32'h0, 32'h0);
        miss("write_miss", 32'h200, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0);
        access(32'h200, 32'h0, 4'h0, 1'b0, rd, st, mq);
        exp_hits++;
        chk("wmiss_readback", rd, 32'hDEADBEEF);
        chk("wmiss_hit_cnt", hit_count, 32'(exp_hits));

        push_line(1'b1, 32'h200, 32'hDEADBEEF, 32'h204, 32'h208, 32'h20C);
        push_line(1'b0, 32'h280, 32'h0, 32'h0, 32'h0, 32'h0);
        miss("evict_wmiss", 32'h280, 32'h0, 4'h0, 1'b0, 32'h280);

        // Abort a refill after its second word with an asynchronous reset.
        push_line(1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0);
        base = xfer_cnt;
        @(negedge clk);
        cache_req_addr = 32'h100; cache_req_wen = 1'b0; cache_req_valid = 1'b1;
        for (int c = 0; c < 200 && xfer_cnt < base + 2; c++) @(posedge clk);
        chk("abort_reached", 32'(xfer_cnt >= base + 2), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_mvalid", {31'd0, mem_req_valid}, 32'd0);
        chk("abort_stall", {31'd0, cache_res_stall}, 32'd0);
        chk("abort_rdata", cache_res_data, 32'd0);
        chk("abort_misses", miss_count, 32'd0);
        exp_q.delete();
        cache_req_valid = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        push_line(1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0);
        miss("post_reset", 32'h100, 32'h0, 4'h0, 1'b0, 32'h100);
        access(32'h108, 32'h0, 4'h0, 1'b0, rd, st, mq);
        exp_hits++;
        chk("post_reset_wb_data", rd, 32'h0000_CCDD);
        chk("post_reset_hit_cnt", hit_count, 32'(exp_hits));

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
